gshare_bpred_p: RTL
===================

Name: gshare_bpred_p

Overview:
- Parametrised gshare direction predictor with a tagged, direct-mapped BTB, sitting in the fetch stage.
- Prediction is registered: one lookup per cycle, result available one cycle later.
- Keeps a speculative global history register (GHR) that advances on predicted branches and is repaired from a per-prediction history checkpoint when a mispredict resolves.
- Successor to the fixed 5-bit / 32-entry predictor. Adds configurable sizes, saturating update on every resolved branch, speculative history with recovery, partial tags, and squash.

Parameters:
- HIST_LEN, 5: GHR width in bits; must be 1..PHT_IDX.
- PHT_IDX, 5: PHT index width; the PHT has 2^PHT_IDX 2-bit counters.
- BTB_IDX, 5: BTB index width; the BTB has 2^BTB_IDX entries.
- TAG_BITS, 24: BTB tag width; PC_SHIFT+BTB_IDX+TAG_BITS must be <=32, and PC_SHIFT+PHT_IDX must be <=32.
- PC_SHIFT, 3: lowest PC bit used for indexing.

Ports:
- CLK  in  1  clock, rising edge
- reset  in  1  asynchronous, active-low reset
- pred_valid  in  1  lookup request for pred_pc this cycle
- pred_pc  in  32  fetch PC to predict
- pred_out_valid  out  1  prediction outputs valid (one cycle after request)
- pred_hit  out  1  BTB tag hit
- pred_taken  out  1  predicted direction (counter MSB)
- pred_target  out  32  BTB target
- pred_hist  out  HIST_LEN  GHR checkpoint used for this lookup
- update_valid  in  1  resolved branch this cycle
- update_eip  in  32  PC of the resolved branch
- update_target  in  32  actual target
- update_taken  in  1  actual direction
- update_mispred  in  1  resolved branch was mispredicted (qualified by update_valid)
- update_hist  in  HIST_LEN  pred_hist returned with the resolved branch

Behaviour:
- Reset (reset=0, asynchronous):
  - all PHT counters = 2'b01 (weakly not-taken);
  - all BTB valid bits = 0; tags and targets don't-care;
  - GHR = 0;
  - all outputs = 0.
- Lookup, at the edge where pred_valid=1:
  - pidx = pred_pc[PC_SHIFT+PHT_IDX-1:PC_SHIFT] XOR zero-extended GHR.
  - bidx = pred_pc[PC_SHIFT+BTB_IDX-1:PC_SHIFT].
  - tag = the next TAG_BITS PC bits above bidx.
  - Registered results: pred_hit = valid[bidx] & tag match; pred_taken = pht[pidx][1]; pred_target = target[bidx]; pred_hist = GHR before any shift this cycle.
  - When pred_valid=0, the outputs hold their values and pred_out_valid=0.
- pred_out_valid = registered (pred_valid & ~(update_valid & update_mispred)). A lookup in the same cycle as a mispredict is squashed.
- Speculative GHR:
  - On a lookup that hits in the BTB, GHR <= {GHR[HIST_LEN-2:0], predicted taken}.
  - On a miss, GHR is unchanged.
  - For HIST_LEN=1, GHR <= predicted taken.
- Update, when update_valid=1:
  - uidx = update_eip index bits XOR update_hist.
  - pht[uidx] saturating: +1 if update_taken (11 stays 11), -1 otherwise (00 stays 00). Every resolved branch updates, not only mispredicts.
  - If update_taken: BTB[update_eip bidx] <= {valid=1, tag, update_target}; an existing entry is overwritten.
  - If not taken: BTB unchanged.
- Recovery, when update_valid & update_mispred:
  - GHR <= {update_hist[HIST_LEN-2:0], update_taken}.
  - This has priority over a same-cycle speculative shift.
- Same-cycle lookup and update to the same PHT or BTB entry: the lookup returns the pre-update contents (read-before-write).
- Reset asserted mid-operation clears all state immediately. The first lookup after deassertion sees reset state.
- Counter encoding: 00 strongly not-taken, 01 weakly not-taken, 10 weakly taken, 11 strongly taken.

Test Plan:
- Reset, then lookup pred_pc=0x0000_1000 -> next cycle: pred_out_valid=1, pred_hit=0, pred_taken=0, pred_hist=0; GHR stays 0.
- Update eip=0x1000, taken, target=0x2000, hist=0, then lookup 0x1000 -> pred_hit=1, pred_target=0x2000, pred_taken=1 (counter 01->10); GHR becomes 00001.
- Four not-taken updates on one index from counter 11 -> counter reads 11,10,01,00,00. Five taken updates from 00 -> counter reads 01,10,11,11,11 (saturation both ends).
- Three hit-and-taken lookups raise GHR to 00111; then a mispredict with update_hist=00001, not taken -> GHR=00010. A lookup in the mispredict cycle gives pred_out_valid=0; the next lookup shows pred_hist=00010.
- Alias: update 0x1000 (taken) then lookup 0x0000_1000 + (1<<(PC_SHIFT+BTB_IDX)) -> same bidx, tag mismatch, pred_hit=0. Same-cycle lookup and update of one entry returns the old target.
- Rerun the above with HIST_LEN=1, PHT_IDX=8, BTB_IDX=6, TAG_BITS=23 -> identical behaviour. Also assert reset mid-stream -> all outputs 0 asynchronously.

Source files
------------

// File: rtl/gshare_bpred_p.sv
// Gshare direction predictor with a tagged direct-mapped BTB for the fetch stage.
// Registered lookup, speculative global history with checkpoint-based repair.
module gshare_bpred_p #(
  parameter int HIST_LEN = 5,
  parameter int PHT_IDX  = 5,
  parameter int BTB_IDX  = 5,
  parameter int TAG_BITS = 24,
  parameter int PC_SHIFT = 3
) (
  input  logic                CLK,
  input  logic                reset,
  input  logic                pred_valid,
  input  logic [31:0]         pred_pc,
  output logic                pred_out_valid,
  output logic                pred_hit,
  output logic                pred_taken,
  output logic [31:0]         pred_target,
  output logic [HIST_LEN-1:0] pred_hist,
  input  logic                update_valid,
  input  logic [31:0]         update_eip,
  input  logic [31:0]         update_target,
  input  logic                update_taken,
  input  logic                update_mispred,
  input  logic [HIST_LEN-1:0] update_hist
);

  // Handshake: a lookup is accepted on every edge with pred_valid=1 (no
  // backpressure); its result is presented on the following cycle with
  // pred_out_valid=1 unless a mispredict resolved in the same cycle.

  localparam int PHT_N = 1 << PHT_IDX;
  localparam int BTB_N = 1 << BTB_IDX;

  logic [1:0]          pht        [PHT_N];
  logic [BTB_N-1:0]    btb_valid;
  logic [TAG_BITS-1:0] btb_tag    [BTB_N];
  logic [31:0]         btb_target [BTB_N];
  logic [HIST_LEN-1:0] ghr;
  logic [HIST_LEN-1:0] ghr_next;

  logic [PHT_IDX-1:0]  pidx;
  logic [PHT_IDX-1:0]  uidx;
  logic [BTB_IDX-1:0]  bidx;
  logic [BTB_IDX-1:0]  ubidx;
  logic [TAG_BITS-1:0] ptag;
  logic [TAG_BITS-1:0] utag;
  logic                lk_hit;
  logic                lk_taken;
  logic                squash;

  // Shift one outcome into a history value; degenerates to the bit itself for HIST_LEN=1.
  function automatic logic [HIST_LEN-1:0] shift_in(input logic [HIST_LEN-1:0] h,
                                                   input logic b);
    logic [HIST_LEN:0] t;
    t = {h, b};
    return t[HIST_LEN-1:0];
  endfunction

  assign pidx     = pred_pc[PC_SHIFT +: PHT_IDX] ^ PHT_IDX'(ghr);
  assign uidx     = update_eip[PC_SHIFT +: PHT_IDX] ^ PHT_IDX'(update_hist);
  assign bidx     = pred_pc[PC_SHIFT +: BTB_IDX];
  assign ubidx    = update_eip[PC_SHIFT +: BTB_IDX];
  assign ptag     = pred_pc[PC_SHIFT+BTB_IDX +: TAG_BITS];
  assign utag     = update_eip[PC_SHIFT+BTB_IDX +: TAG_BITS];
  assign lk_hit   = btb_valid[bidx] && (btb_tag[bidx] == ptag);
  assign lk_taken = pht[pidx][1];
  assign squash   = update_valid & update_mispred;

  // Recovery from the returned checkpoint wins over the speculative shift.
  always_comb begin
    ghr_next = ghr;
    if (squash) begin
      ghr_next = shift_in(update_hist, update_taken);
    end else if (pred_valid && lk_hit) begin
      ghr_next = shift_in(ghr, lk_taken);
    end
  end

  always_ff @(posedge CLK or negedge reset) begin
    if (!reset) begin
      for (int i = 0; i < PHT_N; i++) pht[i] <= 2'b01;
      for (int i = 0; i < BTB_N; i++) begin
        btb_tag[i]    <= '0;
        btb_target[i] <= '0;
      end
      btb_valid      <= '0;
      ghr            <= '0;
      pred_out_valid <= 1'b0;
      pred_hit       <= 1'b0;
      pred_taken     <= 1'b0;
      pred_target    <= '0;
      pred_hist      <= '0;
    end else begin
      ghr            <= ghr_next;
      pred_out_valid <= pred_valid & ~squash;
      // Lookup reads the arrays before this edge's update lands (read-before-write).
      if (pred_valid) begin
        pred_hit    <= lk_hit;
        pred_taken  <= lk_taken;
        pred_target <= btb_target[bidx];
        pred_hist   <= ghr;
      end
      if (update_valid) begin
        if (update_taken) begin
          if (pht[uidx] != 2'b11) pht[uidx] <= pht[uidx] + 2'd1;
          btb_valid[ubidx]  <= 1'b1;
          btb_tag[ubidx]    <= utag;
          btb_target[ubidx] <= update_target;
        end else begin
          if (pht[uidx] != 2'b00) pht[uidx] <= pht[uidx] - 2'd1;
        end
      end
    end
  end

endmodule
